// File: rtl/dram_rd_arbiter.sv
// Round-robin burst arbiter for the DRAM model read port.
// Issues one read per cycle and routes tagged return data back to its owner.
module dram_rd_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 18,
  parameter int LEN_WIDTH   = 10,
  parameter int DELAY_CYCLE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_last,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy,
  output logic                          stray_err,
  output logic                          dram_en_rd,
  output logic [ADDR_WIDTH-1:0]         dram_addr_rd,
  input  logic                          dram_valid,
  input  logic [DATA_WIDTH-1:0]         dram_data_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
    logic          last;
  } tag_t;

  state_t state_q, state_d;

  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         id_q;
  logic [IW-1:0]         gnt_id;
  logic                  gnt_vld;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [LEN_WIDTH-1:0]  gnt_len;
  logic                  en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  tag_t                  tag_q [DELAY_CYCLE];
  tag_t                  head;
  logic [DELAY_CYCLE-1:0] drop_q;
  logic                  stray_q;
  logic                  any_tag;

  always_comb begin
    int idx;
    logic [IW-1:0] cand;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    cand    = '0;
    if (state_q == IDLE && !rst) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        idx  = (int'(ptr_q) + i) % NUM_REQ;
        cand = IW'(idx);
        if (!gnt_vld && req_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt_id  = cand;
        end
      end
    end
  end

  assign gnt_addr = req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
  assign gnt_len  = req_len[int'(gnt_id)*LEN_WIDTH +: LEN_WIDTH];

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // cnt_q counts beats still to issue after the one on the bus now
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (gnt_vld && gnt_len != '0) state_d = BURST;
      BURST: if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
      id_q   <= '0;
      ptr_q  <= '0;
    end else if (state_q == IDLE) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      if (gnt_vld) begin
        ptr_q <= gnt_id;
        id_q  <= gnt_id;
        if (gnt_len != '0) begin
          en_q   <= 1'b1;
          addr_q <= gnt_addr;
          cnt_q  <= gnt_len - LEN_WIDTH'(1);
        end
      end
    end else if (cnt_q == '0) begin
      en_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      addr_q <= addr_q + ADDR_WIDTH'(1);
      cnt_q  <= cnt_q - LEN_WIDTH'(1);
    end
  end

  assign dram_en_rd   = en_q;
  assign dram_addr_rd = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DELAY_CYCLE; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0].v    <= en_q;
      tag_q[0].id   <= id_q;
      tag_q[0].last <= en_q && cnt_q == '0;
      for (int i = 1; i < DELAY_CYCLE; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign head = tag_q[DELAY_CYCLE-1];

  always_comb begin
    rsp_valid = '0;
    rsp_last  = 1'b0;
    rsp_data  = '0;
    if (dram_valid && head.v) begin
      rsp_valid[head.id] = 1'b1;
      rsp_last           = head.last;
      rsp_data           = dram_data_out;
    end
  end

  // Reads issued before a reset may still return; mask them for one DRAM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q  <= '1;
      stray_q <= 1'b0;
    end else begin
      drop_q <= drop_q >> 1;
      if (drop_q == '0 && (dram_valid != head.v)) stray_q <= 1'b1;
    end
  end

  assign stray_err = stray_q;

  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < DELAY_CYCLE; i++) any_tag = any_tag | tag_q[i].v;
  end

  assign busy = (state_q == BURST) || any_tag;

endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Directed bench for dram_rd_arbiter with a one-cycle DRAM read model.
// Inputs change #1 after posedge; outputs are checked at negedge.
module tb_dram_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [35:0] req_addr;
  logic [19:0] req_len;
  logic [1:0]  rsp_valid;
  logic        rsp_last;
  logic [31:0] rsp_data;
  logic        busy;
  logic        stray_err;
  logic        dram_en_rd;
  logic [17:0] dram_addr_rd;
  logic        dram_valid;
  logic [31:0] dram_data_out;

  logic        m_dv = 1'b0;
  logic [31:0] m_data = '0;
  logic        force_v;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dram_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_last(rsp_last),
    .rsp_data(rsp_data), .busy(busy),
    .stray_err(stray_err),
    .dram_en_rd(dram_en_rd), .dram_addr_rd(dram_addr_rd),
    .dram_valid(dram_valid), .dram_data_out(dram_data_out)
  );

  function automatic logic [31:0] memf(input logic [17:0] a);
    return 32'hC0DE_0000 ^ {14'h0, a};
  endfunction

  always @(posedge clk) begin
    m_dv   <= dram_en_rd;
    m_data <= memf(dram_addr_rd);
  end

  assign dram_valid    = m_dv | force_v;
  assign dram_data_out = m_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    #2;
    if (req_ready !== 2'b00) begin
      fails++; $display("FAIL reset_ready got=%b exp=00", req_ready);
    end
    tests++;
    if ({dram_en_rd, dram_addr_rd, rsp_valid, rsp_last, rsp_data, busy, stray_err} !== '0) begin
      fails++; $display("FAIL reset_outputs en=%b addr=%h rv=%b busy=%b stray=%b exp all 0",
                        dram_en_rd, dram_addr_rd, rsp_valid, busy, stray_err);
    end
    tests++;
    req_valid = 2'b00;
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_single();
    logic        e_en;
    logic [17:0] e_addr;
    logic [1:0]  e_rv;
    logic [31:0] e_data;
    req_addr[17:0] = 18'h00100;
    req_len[9:0]   = 10'd4;
    req_valid      = 2'b01;
    @(negedge clk);
    if (req_ready !== 2'b01) begin
      fails++; $display("FAIL single_accept got=%b exp=01", req_ready);
    end
    tests++;
    step();
    req_valid = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e_en   = (k <= 4);
      e_addr = e_en ? 18'h00100 + 18'(k - 1) : 18'h0;
      e_rv   = (k >= 2 && k <= 5) ? 2'b01 : 2'b00;
      e_data = (e_rv != 0) ? memf(18'h00100 + 18'(k - 2)) : 32'h0;
      if (dram_en_rd !== e_en || dram_addr_rd !== e_addr) begin
        fails++; $display("FAIL single_read k=%0d got en=%b addr=%h exp en=%b addr=%h",
                          k, dram_en_rd, dram_addr_rd, e_en, e_addr);
      end
      tests++;
      if (rsp_valid !== e_rv || rsp_data !== e_data || rsp_last !== (k == 5)) begin
        fails++; $display("FAIL single_rsp k=%0d got rv=%b d=%h last=%b exp rv=%b d=%h last=%b",
                          k, rsp_valid, rsp_data, rsp_last, e_rv, e_data, k == 5);
      end
      tests++;
      if (busy !== (k <= 5)) begin
        fails++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, k <= 5);
      end
      tests++;
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  e_rdy;
    logic [1:0]  e_rv;
    logic [31:0] e_data;
    logic        e_last;
    int b, off;
    req_addr = {18'h00300, 18'h00200};
    req_len  = {10'd2, 10'd2};
    req_valid = 2'b11;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      e_rdy  = 2'b00;
      if (c % 3 == 0 && c <= 9) e_rdy = ((c / 3) % 2 == 0) ? 2'b10 : 2'b01;
      e_rv   = 2'b00;
      e_data = 32'h0;
      e_last = 1'b0;
      if (c >= 2) begin
        b   = (c - 2) / 3;
        off = (c - 2) % 3;
        if (off < 2) begin
          e_rv   = (b % 2 == 0) ? 2'b10 : 2'b01;
          e_data = memf(((b % 2 == 0) ? 18'h00300 : 18'h00200) + 18'(off));
          e_last = (off == 1);
        end
      end
      if (req_ready !== e_rdy) begin
        fails++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, e_rdy);
      end
      tests++;
      if (rsp_valid !== e_rv || rsp_data !== e_data || rsp_last !== e_last) begin
        fails++; $display("FAIL rr_rsp c=%0d got rv=%b d=%h last=%b exp rv=%b d=%h last=%b",
                          c, rsp_valid, rsp_data, rsp_last, e_rv, e_data, e_last);
      end
      tests++;
      step();
      if (c == 11) req_valid = 2'b00;
    end
    repeat (2) step();
  endtask

  task automatic test_wrap();
    logic [17:0] exp_a [4];
    exp_a[0] = 18'h3FFFE; exp_a[1] = 18'h3FFFF;
    exp_a[2] = 18'h00000; exp_a[3] = 18'h00001;
    req_addr[17:0] = 18'h3FFFE;
    req_len[9:0]   = 10'd4;
    req_valid      = 2'b01;
    step();
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (dram_en_rd !== 1'b1 || dram_addr_rd !== exp_a[k]) begin
        fails++; $display("FAIL wrap_addr k=%0d got en=%b addr=%h exp en=1 addr=%h",
                          k, dram_en_rd, dram_addr_rd, exp_a[k]);
      end
      tests++;
      step();
    end
    @(negedge clk);
    if (rsp_valid !== 2'b01 || rsp_data !== memf(18'h00001) || rsp_last !== 1'b1) begin
      fails++; $display("FAIL wrap_last_rsp got rv=%b d=%h last=%b exp rv=01 d=%h last=1",
                        rsp_valid, rsp_data, rsp_last, memf(18'h00001));
    end
    tests++;
    repeat (2) step();
  endtask

  task automatic test_zero_len();
    req_len   = {10'd0, 10'd1};
    req_addr  = {18'h00700, 18'h00600};
    req_valid = 2'b10;
    @(negedge clk);
    if (req_ready !== 2'b10) begin
      fails++; $display("FAIL zero_accept got=%b exp=10", req_ready);
    end
    tests++;
    step();
    req_valid = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (dram_en_rd !== 1'b0 || rsp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin
        fails++; $display("FAIL zero_quiet k=%0d got en=%b rv=%b busy=%b rdy=%b exp all 0",
                          k, dram_en_rd, rsp_valid, busy, req_ready);
      end
      tests++;
      step();
    end
    req_valid = 2'b11;
    @(negedge clk);
    if (req_ready !== 2'b01) begin
      fails++; $display("FAIL zero_ptr_advanced got=%b exp=01", req_ready);
    end
    tests++;
    step();
    req_valid = 2'b00;
    repeat (4) step();
  endtask

  task automatic test_reset_mid_burst();
    req_addr[17:0] = 18'h00500;
    req_len[9:0]   = 10'd8;
    req_valid      = 2'b01;
    step();
    req_valid = 2'b00;
    repeat (3) step();
    @(negedge clk);
    if (dram_en_rd !== 1'b1 || dram_addr_rd !== 18'h00503) begin
      fails++; $display("FAIL rstmid_beat3 got en=%b addr=%h exp en=1 addr=00503",
                        dram_en_rd, dram_addr_rd);
    end
    tests++;
    step();
    rst = 1'b1;
    #1;
    if ({dram_en_rd, dram_addr_rd, rsp_valid, rsp_last, rsp_data, busy, req_ready} !== '0) begin
      fails++; $display("FAIL rstmid_outputs got en=%b addr=%h rv=%b busy=%b exp all 0",
                        dram_en_rd, dram_addr_rd, rsp_valid, busy);
    end
    tests++;
    #1;
    rst = 1'b0;
    @(negedge clk);
    if (dram_valid !== 1'b1 || rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
      fails++; $display("FAIL rstmid_late_data got dv=%b rv=%b d=%h exp dv=1 rv=00 d=0",
                        dram_valid, rsp_valid, rsp_data);
    end
    tests++;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (dram_en_rd !== 1'b0 || stray_err !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL rstmid_after k=%0d got en=%b stray=%b busy=%b exp 0 0 0",
                          k, dram_en_rd, stray_err, busy);
      end
      tests++;
      step();
    end
  endtask

  task automatic test_stray();
    force_v = 1'b1;
    @(negedge clk);
    if (rsp_valid !== 2'b00 || stray_err !== 1'b0) begin
      fails++; $display("FAIL stray_during got rv=%b stray=%b exp rv=00 stray=0",
                        rsp_valid, stray_err);
    end
    tests++;
    step();
    force_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (stray_err !== 1'b1) begin
        fails++; $display("FAIL stray_sticky k=%0d got=%b exp=1", k, stray_err);
      end
      tests++;
      step();
    end
    rst = 1'b1;
    #2;
    if (stray_err !== 1'b0) begin
      fails++; $display("FAIL stray_cleared got=%b exp=0", stray_err);
    end
    tests++;
    step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    force_v   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_zero_len();
    test_reset_mid_burst();
    test_stray();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
